// File: rtl/dct_pass_arbiter.sv
// Shares one 8-point DCT engine between a row-pass and a column-pass requester, one block of 8 rows per grant.
// Latency: requester rows reach the engine combinationally; results route back combinationally by tag.
// Backpressure: the engine hold, a full tag FIFO or a non-owner sees rX_hold; e_q_hold follows the tagged owner.
module dct_pass_arbiter #(
    parameter int IW        = 13,
    parameter int QW        = 18,
    parameter int TAG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0][IW-1:0]   r0_di,
    input  logic                 r0_valid,
    output logic                 r0_hold,
    input  logic [2:0]           r0_cnt,
    input  logic [7:0][IW-1:0]   r1_di,
    input  logic                 r1_valid,
    output logic                 r1_hold,
    input  logic [2:0]           r1_cnt,
    output logic [7:0][IW-1:0]   e_di,
    output logic                 e_valid,
    input  logic                 e_hold,
    output logic [2:0]           e_cnt,
    input  logic [7:0][QW-1:0]   e_q,
    input  logic                 e_q_valid,
    output logic                 e_q_hold,
    input  logic [2:0]           e_q_cnt,
    output logic [7:0][QW-1:0]   o0_q,
    output logic                 o0_valid,
    output logic [2:0]           o0_cnt,
    input  logic                 o0_hold,
    output logic [7:0][QW-1:0]   o1_q,
    output logic                 o1_valid,
    output logic [2:0]           o1_cnt,
    input  logic                 o1_hold,
    output logic [1:0]           grant,
    output logic                 err
);

    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);

    // State encoding doubles as the one-hot grant vector.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_OWN0 = 2'b01;
    localparam logic [1:0] S_OWN1 = 2'b10;

    logic [1:0]           state, state_nxt;
    logic                 last, last_nxt;
    logic [TAG_DEPTH-1:0] tag_mem;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        tag_cnt;
    logic                 tag_full, tag_empty, tag_head;
    logic                 own0, own1, src_valid, push, pop;

    assign own0      = (state == S_OWN0);
    assign own1      = (state == S_OWN1);
    assign tag_full  = (tag_cnt == CW'(TAG_DEPTH));
    assign tag_empty = (tag_cnt == '0);
    assign tag_head  = tag_mem[rd_ptr];

    // Engine input side: straight mux of the owner, gated only by tag space.
    assign src_valid = (own0 & r0_valid) | (own1 & r1_valid);
    assign e_valid   = src_valid & ~tag_full;
    assign e_di      = own1 ? r1_di  : r0_di;
    assign e_cnt     = own1 ? r1_cnt : r0_cnt;
    assign r0_hold   = r0_valid & ~(own0 & ~e_hold & ~tag_full);
    assign r1_hold   = r1_valid & ~(own1 & ~e_hold & ~tag_full);
    assign push      = e_valid & ~e_hold;

    // Result side: an untagged result is swallowed (hold low) and flagged via err.
    assign e_q_hold  = ~tag_empty & (tag_head ? o1_hold : o0_hold);
    assign pop       = e_q_valid & ~e_q_hold & ~tag_empty;
    assign o0_valid  = e_q_valid & ~tag_empty & ~tag_head;
    assign o1_valid  = e_q_valid & ~tag_empty &  tag_head;
    assign o0_q      = e_q;
    assign o1_q      = e_q;
    assign o0_cnt    = e_q_cnt;
    assign o1_cnt    = e_q_cnt;
    assign grant     = state;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            S_IDLE: begin
                if (r0_valid && (!r1_valid || last)) begin
                    state_nxt = S_OWN0;
                    last_nxt  = 1'b0;
                end else if (r1_valid) begin
                    state_nxt = S_OWN1;
                    last_nxt  = 1'b1;
                end
            end
            S_OWN0, S_OWN1: begin
                if (push && (e_cnt == 3'd7)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            last    <= 1'b1;
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            if (push) begin
                tag_mem[wr_ptr] <= own1;
                wr_ptr <= (wr_ptr == PW'(TAG_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(TAG_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                tag_cnt <= tag_cnt + CW'(1);
            end else if (pop && !push) begin
                tag_cnt <= tag_cnt - CW'(1);
            end
            if (e_q_valid && tag_empty) begin
                err <= 1'b1;
            end
        end
    end

endmodule
